// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial adder that adds two WIDTH-bit operands LSB first, one bit per
// clock edge. The operation is controlled by a three-state FSM:
//   IDLE  -> SHIFT  -> DONE -> IDLE
//
// A request accepted at edge k takes WIDTH bit-edges (k+1..k+WIDTH). The
// result is published at edge k+WIDTH, as the FSM enters DONE. S and Cout
// change only at that moment, so a partial sum is never visible on S.
//
// Optional feature, macro SERIAL_ADDER_SUB_EN:
//   This macro adds the Sub input. With Sub=1 the block computes
//   A - B - Cin and reports a borrow on Cout. Timing is the same as for an
//   add. Without the macro the block is add-only and has no Sub port.
//
// Parameters:
//   WIDTH  operand/result width in bits (>= 2)
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  begin an operation; honoured only in IDLE
//   A, B   operands, sampled when start is accepted
//   Cin    carry-in (borrow-in when subtracting), sampled with start
//   Sub    (SERIAL_ADDER_SUB_EN only) 1 = subtract, sampled with start
//   busy   high while in SHIFT
//   done   one-cycle pulse while in DONE; S/Cout hold a new result
//   S      registered result
//   Cout   registered carry-out (borrow-out when subtracting)
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             Sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_reg;
  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  b_reg;
  logic              carry_reg;
  logic [WIDTH-1:0]  sum_reg;
  logic [CW-1:0]     cnt_reg;
  logic [WIDTH-1:0]  s_reg;
  logic              cout_reg;
`ifdef SERIAL_ADDER_SUB_EN
  logic              sub_reg;
`endif

  // Bit-slice full adder and operand-load muxing
  logic             sum_bit;
  logic             carry_next;
  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             cout_final;

  always_comb begin
    sum_bit    = a_reg[0] ^ b_reg[0] ^ carry_reg;
    carry_next = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry_reg) |
                 (b_reg[0] & carry_reg);
`ifdef SERIAL_ADDER_SUB_EN
    // The block subtracts as A + ~B + ~Cin. That equals A - B - Cin + 2^WIDTH.
    // The final carry is then the inverse of the borrow.
    b_load     = Sub ? ~B : B;
    c_load     = Sub ? ~Cin : Cin;
    cout_final = sub_reg ? ~carry_next : carry_next;
`else
    b_load     = B;
    c_load     = Cin;
    cout_final = carry_next;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      sum_reg   <= '0;
      cnt_reg   <= '0;
      s_reg     <= '0;
      cout_reg  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_reg   <= 1'b0;
`endif
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg     <= A;
            b_reg     <= b_load;
            carry_reg <= c_load;
            sum_reg   <= '0;
            cnt_reg   <= '0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_reg   <= Sub;
`endif
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          a_reg     <= a_reg >> 1;
          b_reg     <= b_reg >> 1;
          carry_reg <= carry_next;
          sum_reg   <= {sum_bit, sum_reg[WIDTH-1:1]};
          cnt_reg   <= cnt_reg + CW'(1);
          if (cnt_reg == LAST_BIT) begin
            // Publish the last bit directly. It does not pass through
            // sum_reg first, so S updates on the same edge that enters DONE.
            s_reg     <= {sum_bit, sum_reg[WIDTH-1:1]};
            cout_reg  <= cout_final;
            state_reg <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Decoded from the state register only, so no input can glitch them
  assign busy = (state_reg == SHIFT);
  assign done = (state_reg == DONE);
  assign S    = s_reg;
  assign Cout = cout_reg;

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (WIDTH >= 2).
REQ-002 SHALL have port: clk  input  1  rising-edge clock, single clock domain.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  request to begin an operation, sampled on clk.
REQ-005 SHALL have port: A  input  WIDTH  first operand, sampled when start is accepted.
REQ-006 SHALL have port: B  input  WIDTH  second operand, sampled when start is accepted.
REQ-007 SHALL have port: Cin  input  1  carry-in (borrow-in in subtract mode), sampled when start is accepted.
REQ-008 SHALL have port: busy  output  1  high while an operation is in progress (state SHIFT).
REQ-009 SHALL have port: done  output  1  one-cycle pulse: S/Cout hold a new result.
REQ-010 SHALL have port: S  output  WIDTH  registered result.
REQ-011 SHALL have port: Cout  output  1  registered carry-out (borrow-out in subtract mode).

Function
REQ-012 SHALL implement FSM with states IDLE, SHIFT, DONE; reset state IDLE.
REQ-013 SHALL, in IDLE with start=1 at edge k, latch A, B, Cin into internal shift/carry registers, clear bit counter, go to SHIFT.
REQ-014 SHALL, in SHIFT, process one bit per edge, LSB first: sum bit = a0^b0^c, c <= majority(a0,b0,c); shift operands right, shift sum bit into result register from MSB.
REQ-015 SHALL leave SHIFT after exactly WIDTH bit-edges (edges k+1..k+WIDTH), entering DONE at edge k+WIDTH.
REQ-016 SHALL, on entry to DONE, load S with the full WIDTH-bit sum and Cout with the final carry; done=1 for exactly the cycle in DONE; next edge returns to IDLE.
REQ-017 SHALL hold S and Cout unchanged at all times except on entry to DONE (intermediate bits never visible on S).
REQ-018 SHALL ignore start while in SHIFT or DONE; no queuing; A/B/Cin changes after acceptance have no effect.
REQ-019 SHALL produce S = (A + B + Cin) mod 2^WIDTH, Cout = bit WIDTH of A + B + Cin.
REQ-020 SHALL accept start again in IDLE on the edge immediately after DONE (back-to-back period WIDTH+2 cycles).
REQ-021 SHALL drive busy=1 only in SHIFT, done=1 only in DONE; both combinationally from state register, glitch-free w.r.t. inputs.

Reset
REQ-022 SHALL, on rst_n low (any time, asynchronously), force state IDLE, busy=0, done=0, S=0, Cout=0, counter and internal registers 0.
REQ-023 SHALL abort any operation in progress on reset; no done pulse for it after rst_n rises.
REQ-024 SHALL accept start on the first clk edge with rst_n high.

Configuration
REQ-025 SHALL, when macro SERIAL_ADDER_SUB_EN is defined, add port Sub  input  1  (sampled with start): Sub=1 computes S = (A - B - Cin) mod 2^WIDTH, Cout=1 iff borrow (A < B + Cin); Sub=0 behaves as REQ-019.
REQ-026 SHALL, without SERIAL_ADDER_SUB_EN, have no Sub port and add only; timing identical in both builds.

Verification (WIDTH=8)
REQ-027 SHALL cover: reset, start at edge k with A=8'h3C, B=8'h05, Cin=0 -> busy edges k..k+8, done pulse k+8..k+9, S=8'h41, Cout=0.
REQ-028 SHALL cover: A=8'hFF, B=8'h01, Cin=0 -> S=8'h00, Cout=1; then A=8'hFF, B=8'h00, Cin=1 back-to-back at first IDLE edge -> S=8'h00, Cout=1, second done 10 cycles after first.
REQ-029 SHALL cover: start held high with changing A/B during SHIFT -> result from first-sampled operands only, exactly one done per accepted start.
REQ-030 SHALL cover: rst_n low at bit 4 of an operation -> immediately busy=0, S=0, Cout=0, no done; new start after release gives correct result.
REQ-031 SHALL cover (SERIAL_ADDER_SUB_EN build): Sub=1, A=8'h05, B=8'h07, Cin=0 -> S=8'hFE, Cout=1; Sub=1, A=8'h10, B=8'h01, Cin=1 -> S=8'h0E, Cout=0.
